// File: rtl/int_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_n
// Description : Multi-source interrupt controller. Synchronises N_SRC raw
//               lines, applies per-source mask and level/edge mode, keeps
//               pending state, and arbitrates with fixed priority (lowest
//               index wins). One request at a time goes to the CPU over a
//               req/ack/eoi handshake, together with the source ID and the
//               handler vector.
// Options     : INTC_NEST_EN - when defined, a higher-priority source can
//               preempt a source in service; preempted IDs are stacked and
//               restored on int_eoi. STATUS[9:6] then shows stack depth.
// Ports       : clk        - system clock
//               reset      - asynchronous active-low reset
//               irq_in     - raw asynchronous interrupt lines
//               cfg_we     - register write strobe
//               cfg_addr   - register select (0 MASK, 1 MODE, 2 PENDING,
//                            3 STATUS)
//               cfg_wdata  - register write data
//               cfg_rdata  - register read data (combinational on cfg_addr)
//               int_req    - interrupt request to CPU
//               int_id     - ID of requested/serviced source
//               int_vector - VEC_BASE + 4*int_id
//               int_ack    - CPU took the interrupt (pulse)
//               int_eoi    - end of interrupt (pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl_n #(
  parameter int          N_SRC       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_3008,
  parameter int          ID_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  output logic [31:0]      int_vector,
  input  logic             int_ack,
  input  logic             int_eoi
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                              state;
  logic [SYNC_STAGES-1:0][N_SRC-1:0]   sync_q;
  logic [N_SRC-1:0]                    sync_s;
  logic [N_SRC-1:0]                    sync_prev;
  logic [N_SRC-1:0]                    edge_pend;
  logic [N_SRC-1:0]                    mask;
  logic [N_SRC-1:0]                    mode;
  logic [N_SRC-1:0]                    pend;
  logic [N_SRC-1:0]                    elig;
  logic [N_SRC-1:0]                    rise;
  logic [N_SRC-1:0]                    clr;
  logic [ID_W-1:0]                     win;
  logic                                ack_take;
  logic [3:0]                          depth4;
  logic                                unused_wdata;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign rise     = sync_s & ~sync_prev;
  // Level sources are visible straight from the synchroniser; edge sources
  // come from the latched edge register.
  assign pend     = (edge_pend & mode) | (sync_s & ~mode);
  assign elig     = pend & mask;
  assign ack_take = (state == REQ) && int_ack;
  assign unused_wdata = ^cfg_wdata[31:N_SRC];

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win = ID_W'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (cfg_we && cfg_addr == 2'd2) clr = cfg_wdata[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++) begin
      if (ack_take && int_id == ID_W'(i)) clr[i] = 1'b1;
    end
  end

  // Synchroniser, edge detect, edge-pending and configuration registers.
  // A rising edge beats a simultaneous clear; level-mode bits stay zero here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      sync_prev <= '0;
      edge_pend <= '0;
      mask      <= '0;
      mode      <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_in};
      sync_prev <= sync_s;
      edge_pend <= mode & ((edge_pend & ~clr) | rise);
      if (cfg_we && cfg_addr == 2'd0) mask <= cfg_wdata[N_SRC-1:0];
      if (cfg_we && cfg_addr == 2'd1) mode <= cfg_wdata[N_SRC-1:0];
    end
  end

`ifdef INTC_NEST_EN
  logic [3:0]      depth;
  logic [ID_W-1:0] stack [16];
  logic            preempt;

  // eoi takes precedence; a waiting higher-priority source is picked up
  // on the following cycle.
  assign preempt = (state == SERVICE) && !int_eoi && (|elig) && (win < int_id);
  assign depth4  = depth;

  always_ff @(posedge clk) begin
    if (preempt) stack[depth] <= int_id;
  end
`else
  assign depth4 = 4'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      int_req <= 1'b0;
      int_id  <= '0;
`ifdef INTC_NEST_EN
      depth   <= 4'd0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|elig) begin
            int_id  <= win;
            int_req <= 1'b1;
            state   <= REQ;
          end
        end
        // int_id stays frozen here: no retraction once requested.
        REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            state   <= SERVICE;
          end
        end
        SERVICE: begin
          if (int_eoi) begin
`ifdef INTC_NEST_EN
            if (depth != 4'd0) begin
              int_id <= stack[depth - 4'd1];
              depth  <= depth - 4'd1;
            end else begin
              state  <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
`ifdef INTC_NEST_EN
          else if (preempt) begin
            depth   <= depth + 4'd1;
            int_id  <= win;
            int_req <= 1'b1;
            state   <= REQ;
          end
`endif
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

  assign int_vector = VEC_BASE + (32'(int_id) << 2);

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0: cfg_rdata = 32'(mask);
      2'd1: cfg_rdata = 32'(mode);
      2'd2: cfg_rdata = 32'(pend);
      2'd3: cfg_rdata = {22'b0, depth4, state, 4'(int_id)};
      default: cfg_rdata = '0;
    endcase
  end

endmodule
`default_nettype wire
